// File: rtl/updown_counter_mod_pkg.sv
// -----------------------------------------------------------------------------
// updown_counter_mod_pkg
//
// Shared types for the parametrised up/down counter:
//   mode_e : step behaviour at a boundary (wrap modulo, or saturate)
//   dir_e  : step direction
//   op_e   : which action the counter takes on a clock edge (reset excluded,
//            it is handled directly by the register block)
// -----------------------------------------------------------------------------
package updown_counter_mod_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_STEP = 2'd2
    } op_e;

    // Load has priority over a count step; with neither the count holds.
    function automatic op_e decode_op(input logic load, input logic en);
        op_e op;
        op = OP_HOLD;
        if (load) begin
            op = OP_LOAD;
        end else if (en) begin
            op = OP_STEP;
        end
        return op;
    endfunction

endpackage : updown_counter_mod_pkg

// File: rtl/updown_counter_mod_step.sv
// -----------------------------------------------------------------------------
// updown_counter_mod_step
//
// Combinational next-count for one enabled step of a modulo-MODULUS counter.
// The boundary is detected by comparing the current count against the range
// ends before any arithmetic, so the WIDTH-bit adder never depends on a
// natural 2**WIDTH overflow and any MODULUS up to 2**WIDTH wraps correctly.
//
// Ports:
//   i_count    : current registered count (always < MODULUS)
//   i_dir      : DIR_UP / DIR_DOWN
//   i_mode     : MODE_WRAP / MODE_SAT
//   o_next     : count after the step
//   o_boundary : the step started at the boundary in the step direction
// -----------------------------------------------------------------------------
module updown_counter_mod_step
    import updown_counter_mod_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 32'd1 << WIDTH
) (
    input  logic [WIDTH-1:0] i_count,
    input  dir_e             i_dir,
    input  mode_e            i_mode,
    output logic [WIDTH-1:0] o_next,
    output logic             o_boundary
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 32'd1);

    logic w_at_max;
    logic w_at_min;

    assign w_at_max = (i_count == MAX_VAL);
    assign w_at_min = (i_count == '0);

    always_comb begin
        o_next     = i_count;
        o_boundary = 1'b0;
        if (i_dir == DIR_UP) begin
            if (w_at_max) begin
                o_boundary = 1'b1;
                o_next     = (i_mode == MODE_WRAP) ? '0 : i_count;
            end else begin
                o_next = i_count + WIDTH'(1);
            end
        end else begin
            if (w_at_min) begin
                o_boundary = 1'b1;
                o_next     = (i_mode == MODE_WRAP) ? MAX_VAL : i_count;
            end else begin
                o_next = i_count - WIDTH'(1);
            end
        end
    end

endmodule : updown_counter_mod_step

// File: rtl/updown_counter_mod.sv
// -----------------------------------------------------------------------------
// updown_counter_mod
//
// Parametrised up/down counter with parallel load, count enable and a
// per-cycle wrap/saturate mode. Count range is 0..MODULUS-1.
//
// Parameters:
//   WIDTH   : width of Count and LoadVal, 2..16
//   MODULUS : number of count states, 2..2**WIDTH
//
// Ports:
//   Clk      : rising-edge clock
//   reset    : synchronous active-high reset, clears Count and Limit
//   En       : count enable (ignored while Load=1)
//   UpOrDown : 1 = count up, 0 = count down
//   Load     : parallel load strobe; LoadVal >= MODULUS clamps to MODULUS-1
//   LoadVal  : value to load
//   Mode     : 0 = wrap (modulo), 1 = saturate
//   Count    : registered count
//   AtMax    : Count == MODULUS-1 (decoded from the register)
//   AtMin    : Count == 0 (decoded from the register)
//   Limit    : registered pulse, the last enabled step hit a boundary
//
// Edge priority: reset > Load > En > hold.
// -----------------------------------------------------------------------------
module updown_counter_mod
    import updown_counter_mod_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 32'd1 << WIDTH
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             En,
    input  logic             UpOrDown,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             Mode,
    output logic [WIDTH-1:0] Count,
    output logic             AtMax,
    output logic             AtMin,
    output logic             Limit
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $fatal(1, "updown_counter_mod: WIDTH must be in 2..16");
    end
    if (MODULUS < 2) begin : g_bad_mod_min
        $fatal(1, "updown_counter_mod: MODULUS must be at least 2");
    end
    if (MODULUS > (32'd1 << WIDTH)) begin : g_bad_mod_max
        $fatal(1, "updown_counter_mod: MODULUS must not exceed 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 32'd1);

    logic [WIDTH-1:0] r_count;
    logic             r_limit;

    logic [WIDTH-1:0] w_load_count;
    logic [WIDTH-1:0] w_step_count;
    logic             w_step_boundary;
    op_e              w_op;

    // -------------------------------------------------------------------------
    // Next-state pieces
    // -------------------------------------------------------------------------
    assign w_op = decode_op(Load, En);

    // Compare in 32 bits so LoadVal values above MODULUS-1 are seen even when
    // MODULUS == 2**WIDTH (then no clamp can ever fire).
    always_comb begin
        w_load_count = LoadVal;
        if (32'(LoadVal) > (MODULUS - 32'd1)) begin
            w_load_count = MAX_VAL;
        end
    end

    updown_counter_mod_step #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_step (
        .i_count    (r_count),
        .i_dir      (dir_e'(UpOrDown)),
        .i_mode     (mode_e'(Mode)),
        .o_next     (w_step_count),
        .o_boundary (w_step_boundary)
    );

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_count <= '0;
            r_limit <= 1'b0;
        end else begin
            unique case (w_op)
                OP_LOAD: begin
                    r_count <= w_load_count;
                    r_limit <= 1'b0;
                end
                OP_STEP: begin
                    r_count <= w_step_count;
                    r_limit <= w_step_boundary;
                end
                default: begin
                    r_limit <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign Count = r_count;
    assign Limit = r_limit;
    assign AtMax = (r_count == MAX_VAL);
    assign AtMin = (r_count == '0);

endmodule : updown_counter_mod
